copro_result_buffer: RTL and testbench

- Sits directly downstream of the coprocessor ALU stage, which registers one result per cycle and has no backpressure.
- Captures each ALU result (data, hartid, id, rd, we) into an in-order circular FIFO.
- Presents the oldest entry on the CV-X-IF result channel using a valid/ready handshake.
- Generates a look-ahead stall for the issue stage, so that an instruction already in the ALU's 1-cycle pipeline always finds a free slot.

---
 rtl/copro_result_buffer.sv | 114 +++++++++++
 tb/tb_copro_result_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/copro_result_buffer.sv
// Result buffer between the coprocessor ALU stage and the CV-X-IF result
// channel. ALU results land in an in-order circular FIFO. The oldest entry
// is offered with a valid/ready handshake, and the issue stage gets a
// look-ahead stall that always leaves a slot for the result still in the ALU.
module copro_result_buffer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter type hartid_t      = logic,
    parameter type id_t          = logic
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     alu_valid_i,
    input  logic [XLEN-1:0]          alu_result_i,
    input  hartid_t                  alu_hartid_i,
    input  id_t                      alu_id_i,
    input  logic [4:0]               alu_rd_i,
    input  logic                     alu_we_i,
    output logic                     issue_stall_o,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [XLEN-1:0]          result_data_o,
    output hartid_t                  result_hartid_o,
    output id_t                      result_id_o,
    output logic [4:0]               result_rd_o,
    output logic                     result_we_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Entry storage; contents are never reset, occupancy comes from count
    logic [XLEN-1:0] data_mem   [DEPTH];
    hartid_t         hartid_mem [DEPTH];
    id_t             id_mem     [DEPTH];
    logic [4:0]      rd_mem     [DEPTH];
    logic            we_mem     [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             overflow;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // Handshake decode: a pop frees a slot in the same cycle, so a full
    // buffer can still accept a push while its head is being consumed
    always_comb begin
        full       = (count == CNT_W'(DEPTH));
        pop        = (count != '0) && result_ready_i;
        push       = alu_valid_i && (!full || pop);
        drop       = alu_valid_i && full && !pop;
        count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    // Control state: pointers wrap naturally at DEPTH, overflow is sticky
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Payload write at the tail; a dropped push leaves storage untouched
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr]   <= alu_result_i;
            hartid_mem[wr_ptr] <= alu_hartid_i;
            id_mem[wr_ptr]     <= alu_id_i;
            rd_mem[wr_ptr]     <= alu_rd_i;
            we_mem[wr_ptr]     <= alu_we_i;
        end
    end

    // Head presentation straight from storage, forced to zero when empty;
    // the stall only looks at registered occupancy, never at result_ready_i
    always_comb begin
        result_valid_o  = (count != '0);
        result_data_o   = '0;
        result_hartid_o = '0;
        result_id_o     = '0;
        result_rd_o     = '0;
        result_we_o     = 1'b0;
        if (result_valid_o) begin
            result_data_o   = data_mem[rd_ptr];
            result_hartid_o = hartid_mem[rd_ptr];
            result_id_o     = id_mem[rd_ptr];
            result_rd_o     = rd_mem[rd_ptr];
            result_we_o     = we_mem[rd_ptr];
        end
        issue_stall_o = (count >= CNT_W'(DEPTH - 1));
        count_o       = count;
        overflow_o    = overflow;
    end

endmodule

// File: tb/tb_copro_result_buffer.sv
// Self-checking bench for copro_result_buffer with a queue scoreboard.
module tb_copro_result_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef logic [1:0] hart_t;
    typedef logic [3:0] idt_t;

    typedef struct packed {
        logic [31:0] data;
        hart_t       hart;
        idt_t        id;
        logic [4:0]  rd;
        logic        we;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        alu_valid_i = 1'b0;
    logic [31:0] alu_result_i = '0;
    hart_t       alu_hartid_i = '0;
    idt_t        alu_id_i = '0;
    logic [4:0]  alu_rd_i = '0;
    logic        alu_we_i = 1'b0;
    logic        issue_stall_o;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [31:0] result_data_o;
    hart_t       result_hartid_o;
    idt_t        result_id_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic [2:0]  count_o;
    logic        overflow_o;

    int     tests = 0;
    int     fails = 0;
    int     viol_cnt = 0;
    entry_t sb[$];
    bit     model_ovf = 1'b0;

    copro_result_buffer #(
        .XLEN(XLEN), .DEPTH(DEPTH), .hartid_t(hart_t), .id_t(idt_t)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .alu_valid_i(alu_valid_i), .alu_result_i(alu_result_i),
        .alu_hartid_i(alu_hartid_i), .alu_id_i(alu_id_i),
        .alu_rd_i(alu_rd_i), .alu_we_i(alu_we_i),
        .issue_stall_o(issue_stall_o),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_data_o(result_data_o), .result_hartid_o(result_hartid_o),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o),
        .result_we_o(result_we_o), .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Protocol monitor: a push into a full buffer without a pop is illegal
    always @(posedge clk) begin
        if (!rst_i && alu_valid_i && count_o == 3'(DEPTH) && !(result_valid_o && result_ready_i)) begin
            viol_cnt++;
            $display("[TB] protocol violation: push to full buffer at %0t", $time);
        end
    end

    function automatic entry_t mk(input logic [31:0] d, input hart_t h, input idt_t id,
                                  input logic [4:0] rd, input logic we);
        entry_t e;
        e.data = d; e.hart = h; e.id = id; e.rd = rd; e.we = we;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus and advance the queue model; returns the
    // values the DUT must show during this cycle (state before the edge)
    task automatic step(input bit v, input entry_t e, input bit rdy,
                        output bit ev, output entry_t eh, output int ec,
                        output bit es, output bit eo);
        alu_valid_i    = v;
        alu_result_i   = e.data;
        alu_hartid_i   = e.hart;
        alu_id_i       = e.id;
        alu_rd_i       = e.rd;
        alu_we_i       = e.we;
        result_ready_i = rdy;
        ev = (sb.size() != 0);
        eh = ev ? sb[0] : '0;
        ec = sb.size();
        es = (sb.size() >= DEPTH - 1);
        eo = model_ovf;
        if (ev && rdy) void'(sb.pop_front());
        if (v) begin
            if (sb.size() < DEPTH) sb.push_back(e);
            else model_ovf = 1'b1;
        end
    endtask

    task automatic test_reset();
        entry_t got;
        #2;
        got = {result_data_o, result_hartid_o, result_id_o, result_rd_o, result_we_o};
        tests++; if (result_valid_o !== 1'b0) begin fails++; $display("FAIL reset valid: got %0b expected 0", result_valid_o); end
        tests++; if (got !== '0) begin fails++; $display("FAIL reset payload: got %h expected 0", got); end
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL reset count: got %0d expected 0", count_o); end
        tests++; if (issue_stall_o !== 1'b0) begin fails++; $display("FAIL reset stall: got %0b expected 0", issue_stall_o); end
        tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL reset overflow: got %0b expected 0", overflow_o); end
        tick();
        rst_i = 1'b0;
        tick();
        tick();
        tests++; if (result_valid_o !== 1'b0 || count_o !== 3'd0 || issue_stall_o !== 1'b0) begin
            fails++; $display("FAIL idle state: got valid=%0b count=%0d stall=%0b expected 0/0/0", result_valid_o, count_o, issue_stall_o);
        end
    endtask

    task automatic test_single();
        bit ev, es, eo; entry_t eh, got; int ec;
        for (int i = 0; i < 3; i++) begin
            step(i == 0, mk(32'h0000_00AB, 2'd0, 4'd1, 5'd5, 1'b1), i < 2, ev, eh, ec, es, eo);
            got = {result_data_o, result_hartid_o, result_id_o, result_rd_o, result_we_o};
            tests++; if (result_valid_o !== ev) begin fails++; $display("FAIL single valid c%0d: got %0b expected %0b", i, result_valid_o, ev); end
            tests++; if (got !== eh) begin fails++; $display("FAIL single payload c%0d: got %h expected %h", i, got, eh); end
            tests++; if (count_o !== ec[2:0]) begin fails++; $display("FAIL single count c%0d: got %0d expected %0d", i, count_o, ec); end
            tests++; if (issue_stall_o !== es) begin fails++; $display("FAIL single stall c%0d: got %0b expected %0b", i, issue_stall_o, es); end
            tick();
        end
    endtask

    task automatic test_fill_drain();
        bit ev, es, eo; entry_t eh, got; int ec;
        for (int i = 0; i < 11; i++) begin
            step(i < 4, mk(32'h1000 + i, 2'(i), 4'(i + 1), 5'(i + 10), 1'b1), i >= 6, ev, eh, ec, es, eo);
            got = {result_data_o, result_hartid_o, result_id_o, result_rd_o, result_we_o};
            tests++; if (result_valid_o !== ev) begin fails++; $display("FAIL fill valid c%0d: got %0b expected %0b", i, result_valid_o, ev); end
            tests++; if (got !== eh) begin fails++; $display("FAIL fill payload c%0d: got %h expected %h", i, got, eh); end
            tests++; if (count_o !== ec[2:0]) begin fails++; $display("FAIL fill count c%0d: got %0d expected %0d", i, count_o, ec); end
            tests++; if (issue_stall_o !== es) begin fails++; $display("FAIL fill stall c%0d: got %0b expected %0b", i, issue_stall_o, es); end
            tick();
        end
    endtask

    task automatic test_full_push_pop();
        bit ev, es, eo; entry_t eh, got; int ec;
        for (int i = 0; i < 10; i++) begin
            step(i < 5, mk(32'h2000 + i, 2'd1, 4'(i + 1), 5'(i + 1), 1'b1), i >= 4, ev, eh, ec, es, eo);
            got = {result_data_o, result_hartid_o, result_id_o, result_rd_o, result_we_o};
            tests++; if (result_valid_o !== ev) begin fails++; $display("FAIL fullpp valid c%0d: got %0b expected %0b", i, result_valid_o, ev); end
            tests++; if (got !== eh) begin fails++; $display("FAIL fullpp payload c%0d: got %h expected %h", i, got, eh); end
            tests++; if (count_o !== ec[2:0]) begin fails++; $display("FAIL fullpp count c%0d: got %0d expected %0d", i, count_o, ec); end
            tests++; if (overflow_o !== eo) begin fails++; $display("FAIL fullpp overflow c%0d: got %0b expected %0b", i, overflow_o, eo); end
            tick();
        end
    endtask

    task automatic test_nop_wrap();
        bit ev, es, eo; entry_t eh, got, e; int ec;
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) e = mk(32'h0, 2'd2, 4'(i), 5'd0, 1'b0);
            else            e = mk(32'h111 * i, 2'd3, 4'(i), 5'(i), 1'b1);
            step(i < 10, e, i < 11, ev, eh, ec, es, eo);
            got = {result_data_o, result_hartid_o, result_id_o, result_rd_o, result_we_o};
            tests++; if (result_valid_o !== ev) begin fails++; $display("FAIL nop valid c%0d: got %0b expected %0b", i, result_valid_o, ev); end
            tests++; if (got !== eh) begin fails++; $display("FAIL nop payload c%0d: got %h expected %h", i, got, eh); end
            tests++; if (count_o !== ec[2:0]) begin fails++; $display("FAIL nop count c%0d: got %0d expected %0d", i, count_o, ec); end
            tick();
        end
    endtask

    task automatic test_overflow();
        bit ev, es, eo; entry_t eh, got; int ec, v0;
        v0 = viol_cnt;
        for (int i = 0; i < 12; i++) begin
            step(i < 5, mk(32'h3000 + i, 2'd0, (i == 4) ? 4'd6 : 4'(i + 1), 5'(i + 2), 1'b1),
                 i >= 7, ev, eh, ec, es, eo);
            got = {result_data_o, result_hartid_o, result_id_o, result_rd_o, result_we_o};
            tests++; if (result_valid_o !== ev) begin fails++; $display("FAIL ovf valid c%0d: got %0b expected %0b", i, result_valid_o, ev); end
            tests++; if (got !== eh) begin fails++; $display("FAIL ovf payload c%0d: got %h expected %h", i, got, eh); end
            tests++; if (count_o !== ec[2:0]) begin fails++; $display("FAIL ovf count c%0d: got %0d expected %0d", i, count_o, ec); end
            tests++; if (overflow_o !== eo) begin fails++; $display("FAIL ovf flag c%0d: got %0b expected %0b", i, overflow_o, eo); end
            tick();
        end
        tests++; if (viol_cnt - v0 != 1) begin fails++; $display("FAIL ovf monitor: got %0d violations expected 1", viol_cnt - v0); end
    endtask

    task automatic test_reset_mid();
        bit ev, es, eo; entry_t eh, got; int ec;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(32'h4000 + i, 2'd1, 4'(i + 1), 5'(i + 3), 1'b1), 1'b0, ev, eh, ec, es, eo);
            tick();
        end
        step(1'b0, '0, 1'b1, ev, eh, ec, es, eo);
        tests++; if (count_o !== 3'd3 || result_valid_o !== 1'b1) begin
            fails++; $display("FAIL midrst pre: got count=%0d valid=%0b expected 3/1", count_o, result_valid_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        got = {result_data_o, result_hartid_o, result_id_o, result_rd_o, result_we_o};
        tests++; if (result_valid_o !== 1'b0) begin fails++; $display("FAIL midrst valid: got %0b expected 0", result_valid_o); end
        tests++; if (got !== '0) begin fails++; $display("FAIL midrst payload: got %h expected 0", got); end
        tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL midrst overflow: got %0b expected 0", overflow_o); end
        sb.delete();
        model_ovf = 1'b0;
        alu_valid_i = 1'b0;
        result_ready_i = 1'b0;
        tick();
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL midrst count: got %0d expected 0", count_o); end
        rst_i = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            step(i == 0, mk(32'h5555_0007, 2'd2, 4'd7, 5'd7, 1'b1), 1'b1, ev, eh, ec, es, eo);
            got = {result_data_o, result_hartid_o, result_id_o, result_rd_o, result_we_o};
            tests++; if (result_valid_o !== ev) begin fails++; $display("FAIL postrst valid c%0d: got %0b expected %0b", i, result_valid_o, ev); end
            tests++; if (got !== eh) begin fails++; $display("FAIL postrst payload c%0d: got %h expected %h", i, got, eh); end
            tests++; if (count_o !== ec[2:0]) begin fails++; $display("FAIL postrst count c%0d: got %0d expected %0d", i, count_o, ec); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_full_push_pop();
        test_nop_wrap();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
